pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the five-stage pipeline. Merges stall requests
//  from ID (load-use), EX (multi-cycle ops) and MEM into one per-stage hold vector
//  that drives pc_reg, if_id, id_ex, ex_mem and mem_wb.
//  Sequences exception flushes with a latched redirect PC and a refill window.
//  Watches for stalls that never release.
// PARAMETERS
//  REFILL_CYCLES  1    cycles after a flush in which new exceptions are refused (1..15)
//  MAX_STALL      64   consecutive stall cycles before stall_timeout sets (2..1023)
// PORTS
//  clk            in   1   pipeline clock, rising edge
//  rst            in   1   asynchronous active-high reset
//  stallreq_id    in   1   ID needs a hold (load-use)
//  stallreq_ex    in   1   EX needs a hold (mul/div busy)
//  stallreq_mem   in   1   MEM needs a hold (memory wait)
//  excp_req       in   1   exception raised at MEM, handler address on excp_pc
//  excp_pc        in   32  handler address, sampled with excp_req
//  stall          out  6   [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB (reserved, always 0)
//  flush          out  1   clear all pipeline registers this cycle
//  new_pc         out  32  redirect target, valid while flush=1
//  excp_busy      out  1   high in ACCEPT/FLUSH/REFILL; excp_req ignored
//  stall_timeout  out  1   sticky: a stall was held MAX_STALL consecutive cycles
// BEHAVIOUR
//  Reset values: stall=0, flush=0, new_pc=0, excp_busy=0, stall_timeout=0,
//    state=RUN, stall_run counter=0, refill counter=0.
//  FSM states: RUN, ACCEPT, FLUSH, REFILL.
//  RUN: stall is combinational from the requests, highest stage wins:
//    mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else 0.
//    A stage that is held while the next stage is not held receives a bubble.
//    The pipeline registers produce this from stall[n] & ~stall[n+1].
//    excp_req=1: latch excp_pc, go to ACCEPT. Stall requests still drive stall in this cycle.
//  ACCEPT (1 cycle): stall=6'b011111, excp_busy=1, go to FLUSH.
//  FLUSH (1 cycle): flush=1, new_pc=latched excp_pc, stall=0, excp_busy=1, go to REFILL.
//  REFILL (REFILL_CYCLES cycles): flush=0, stall still follows requests as in RUN,
//    excp_busy=1, excp_req dropped (not queued). Returns to RUN when the count expires.
//  new_pc holds its last value outside FLUSH.
//  Watchdog:
//    - stall_run increments each cycle stall!=0 and clears when stall==0.
//    - It saturates at MAX_STALL.
//    - stall_timeout sets on the clock edge where stall_run reaches MAX_STALL.
//    - stall_timeout stays set until rst.
//    - stall_run clears in FLUSH, and forced stalls in ACCEPT do count.
//  Simultaneous excp_req with any stall request: the exception is accepted.
//  Reset asserted mid-sequence: everything returns to reset values at once.
//    A pending redirect is lost.
//  excp_req held high across states: accepted once. It is re-accepted only when
//    still high in RUN after REFILL.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined adds two outputs:
//    perf_stall_cyc  out 32  counts cycles with stall!=0, wraps at 2^32.
//    perf_flush_cnt  out 16  counts entries to FLUSH, wraps at 2^16.
//    Both reset to 0.
//  Undefined: these ports and their counters do not exist. All other behaviour is identical.
// TESTING
//  1 Reset: rst=1 with random inputs -> all outputs 0. Release -> state RUN.
//  2 Priority: id=1 -> stall=000111. id=1,ex=1 -> 001111. id=1,ex=1,mem=1 -> 011111.
//    All 0 -> 000000 in the same cycle.
//  3 Exception: excp_req=1, excp_pc=32'h0000_0040 at cycle T.
//    -> stall=011111 at T+1. flush=1 and new_pc=32'h40 at T+2.
//    -> excp_busy high T+1..T+3. excp_req at T+3 ignored (REFILL_CYCLES=1).
//  4 Exception with stallreq_ex=1 at T -> exception accepted. Same T+2 flush, perf_flush_cnt=1.
//  5 Watchdog: MAX_STALL=4, stallreq_id held 4 cycles -> stall_timeout=1 after the 4th edge.
//    The flag stays set after the request drops. Only 3 held cycles -> stays 0.
//  6 Async reset asserted in FLUSH -> flush and new_pc drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundles the stall/flush handshake between the pipeline stages and the
//   central sequencer pipe_ctrl.
//   Signals:
//     stallreq_id   1   ID hold request (load-use)
//     stallreq_ex   1   EX hold request (mul/div busy)
//     stallreq_mem  1   MEM hold request (memory wait)
//     excp_req      1   exception raised at MEM
//     excp_pc       32  handler address, sampled with excp_req
//     stall         6   per-stage hold vector, [0]=PC .. [4]=MEM/WB, [5]=0
//     flush         1   clear all pipeline registers this cycle
//     new_pc        32  redirect target, valid while flush=1
//     excp_busy     1   exception sequence in progress, excp_req ignored
//     stall_timeout 1   sticky stall watchdog flag
//   Modports:
//     master  pipeline side (drives requests, receives controls)
//     slave   pipe_ctrl side
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        excp_busy;
  logic        stall_timeout;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
    input  stall, flush, new_pc, excp_busy, stall_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
    output stall, flush, new_pc, excp_busy, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central stall/flush sequencer for the five-stage pipeline. Merges the
//   ID/EX/MEM stall requests into a per-stage hold vector, sequences
//   exception flushes (ACCEPT -> FLUSH -> REFILL) with a latched redirect PC,
//   and flags stalls that are held for MAX_STALL consecutive cycles.
//   Parameters:
//     REFILL_CYCLES  cycles after a flush in which exceptions are refused (1..15)
//     MAX_STALL      consecutive stall cycles before stall_timeout sets (2..1023)
//   Ports:
//     clk   in  pipeline clock, rising edge
//     rst   in  asynchronous active-high reset
//     bus   pipe_ctrl_if.slave (requests in, stall/flush/new_pc/status out)
//   Optional feature (macro PIPE_PERF_CNT_EN):
//     perf_stall_cyc  out 32  cycles with stall!=0, wrapping
//     perf_flush_cnt  out 16  entries to FLUSH, wrapping
module pipe_ctrl #(
  parameter int REFILL_CYCLES = 1,
  parameter int MAX_STALL     = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int              RUN_W       = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] MAX_RUN     = RUN_W'(MAX_STALL);
  localparam logic [3:0]       REFILL_LAST = 4'(REFILL_CYCLES - 1);

  typedef enum logic [1:0] {RUN, ACCEPT, FLUSH, REFILL} state_t;

  state_t           state;
  state_t           state_next;
  logic [5:0]       req_stall;
  logic [5:0]       stall_c;
  logic             flush_c;
  logic             busy_c;
  logic [31:0]      excp_pc_q;
  logic [31:0]      new_pc_q;
  logic [3:0]       refill_cnt;
  logic [RUN_W-1:0] stall_run;
  logic             timeout_q;

  // Request merge: the highest stalled stage holds itself and everything
  // upstream of it.
  always_comb begin
    req_stall = 6'b000000;
    if (bus.stallreq_mem)     req_stall = 6'b011111;
    else if (bus.stallreq_ex) req_stall = 6'b001111;
    else if (bus.stallreq_id) req_stall = 6'b000111;
  end

  // Next-state and output decode for the exception sequencer.
  always_comb begin
    state_next = state;
    stall_c    = 6'b000000;
    flush_c    = 1'b0;
    busy_c     = 1'b0;
    case (state)
      RUN: begin
        stall_c = req_stall;
        if (bus.excp_req) state_next = ACCEPT;
      end
      ACCEPT: begin
        stall_c    = 6'b011111;
        busy_c     = 1'b1;
        state_next = FLUSH;
      end
      FLUSH: begin
        flush_c    = 1'b1;
        busy_c     = 1'b1;
        state_next = REFILL;
      end
      REFILL: begin
        stall_c = req_stall;
        busy_c  = 1'b1;
        if (refill_cnt == 4'd0) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    // The request merge is combinational, so it must be masked while reset
    // is asserted to present an all-zero hold vector.
    if (rst) stall_c = 6'b000000;
  end

  // State register, redirect latch, refill window and stall watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      excp_pc_q  <= 32'd0;
      new_pc_q   <= 32'd0;
      refill_cnt <= 4'd0;
      stall_run  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == RUN && bus.excp_req) excp_pc_q <= bus.excp_pc;
      // new_pc only changes on the edge into FLUSH so it holds outside it.
      if (state == ACCEPT) new_pc_q <= excp_pc_q;
      if (state == FLUSH) refill_cnt <= REFILL_LAST;
      else if (state == REFILL && refill_cnt != 4'd0) refill_cnt <= refill_cnt - 4'd1;
      if (state == FLUSH || stall_c == 6'b000000) stall_run <= '0;
      else if (stall_run != MAX_RUN) stall_run <= stall_run + RUN_W'(1);
      if (stall_c != 6'b000000 && stall_run == MAX_RUN - RUN_W'(1)) timeout_q <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters; ACCEPT always leads into FLUSH, so counting on
  // ACCEPT counts FLUSH entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_cnt <= 16'd0;
    end else begin
      if (stall_c != 6'b000000) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (state == ACCEPT) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_q;
  assign bus.excp_busy     = busy_c;
  assign bus.stall_timeout = timeout_q;

endmodule
